// File: rtl/div32_seq.sv
// div32_seq: sequential 32-bit restoring divider, signed or unsigned.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; accepted only when idle
//   signed_op    1 = two's-complement divide, 0 = unsigned (sampled with start)
//   op1, op2     dividend, divisor (sampled with start)
//   busy         high while an operation is in progress (CALC or FIN)
//   done         one-cycle completion pulse
//   quot, rem    registered quotient / remainder
//   div_by_zero  registered flag: completed operation had op2 = 0
//
// Timing: acceptance edge E0, iterations on E1..E32, FIN entered at E32,
// results registered at E33 and done high during the following cycle.
module div32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFin
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;    // dividend magnitude, shifted out as quotient shifts in
    logic [31:0] part_q, part_d;  // partial remainder
    logic [31:0] dvs_q, dvs_d;    // divisor magnitude
    logic [31:0] op1_q, op1_d;    // raw dividend, returned as remainder on divide-by-zero
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        dbz_q, dbz_d;

    logic [31:0] mag1, mag2;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] quo_fix, part_fix;

    always_comb begin
        mag1     = (signed_op && op1[31]) ? (~op1 + 32'd1) : op1;
        mag2     = (signed_op && op2[31]) ? (~op2 + 32'd1) : op2;
        shifted  = {part_q, quo_q[31]};
        // part_q < dvs_q always holds, so bit 32 of a 33-bit difference is the sign.
        diff     = shifted - {1'b0, dvs_q};
        quo_fix  = qneg_q ? (~quo_q + 32'd1) : quo_q;
        part_fix = rneg_q ? (~part_q + 32'd1) : part_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        part_d  = part_q;
        dvs_d   = dvs_q;
        op1_d   = op1_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    quo_d   = mag1;
                    dvs_d   = mag2;
                    part_d  = 32'd0;
                    op1_d   = op1;
                    qneg_d  = signed_op && (op1[31] ^ op2[31]);
                    rneg_d  = signed_op && op1[31];
                    zero_d  = (op2 == 32'd0);
                    cnt_d   = 5'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (!diff[32]) begin
                    part_d = diff[31:0];
                    quo_d  = {quo_q[30:0], 1'b1};
                end else begin
                    part_d = shifted[31:0];
                    quo_d  = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (zero_q) begin
                    quot_d = 32'hFFFF_FFFF;
                    rem_d  = op1_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = quo_fix;
                    rem_d  = part_fix;
                    dbz_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            quo_q   <= 32'd0;
            part_q  <= 32'd0;
            dvs_q   <= 32'd0;
            op1_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            part_q  <= part_d;
            dvs_q   <= dvs_d;
            op1_q   <= op1_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed self-checking bench for div32_seq.
module tb_div32_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;
    logic [31:0] hold_q = 32'd0;
    logic [31:0] hold_r = 32'd0;

    div32_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .op1         (op1),
        .op2         (op2),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request now; returns #1 after the acceptance edge E0.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        signed_op = s;
        op1       = a;
        op2       = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_e0", {31'd0, busy}, 32'd1);
        chk("done_after_e0", {31'd0, done}, 32'd0);
    endtask

    // Called #1 after E0; returns #1 after E33 (the done cycle) or on timeout.
    // pulse_at != 0 pulses start with 9/2 so that edge E<pulse_at> samples it.
    task automatic wait_done(input string tag, input int pulse_at, input logic [31:0] eq,
                             input logic [31:0] er, input logic ed);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            if (pulse_at != 0 && n == pulse_at - 1) begin
                signed_op = 1'b0;
                op1       = 32'd9;
                op2       = 32'd2;
                start     = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (pulse_at != 0 && n == pulse_at) start = 1'b0;
            if (n == 20) begin
                chk({tag, "_hold_quot"}, quot, hold_q);
                chk({tag, "_hold_rem"}, rem, hold_r);
                chk({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
            end
            if (done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(n), 32'd33);
        chk({tag, "_quot"}, quot, eq);
        chk({tag, "_rem"}, rem, er);
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ed});
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        hold_q = eq;
        hold_r = er;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        op1       = 32'd0;
        op2       = 32'd0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quot", quot, 32'd0);
        chk("rst_rem", rem, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk); launch(1'b0, 32'd7, 32'd4);
        wait_done("u7_4", 0, 32'd1, 32'd3, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        @(negedge clk); launch(1'b1, 32'hFFFF_FFF9, 32'd4);
        wait_done("s_m7_4", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        @(negedge clk); launch(1'b1, 32'd4, 32'hFFFF_FFF9);
        wait_done("s_4_m7", 0, 32'd0, 32'd4, 1'b0);

        @(negedge clk); launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("s_ovf", 0, 32'h8000_0000, 32'd0, 1'b0);

        @(negedge clk); launch(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done("u_max_1", 0, 32'hFFFF_FFFF, 32'd0, 1'b0);

        @(negedge clk); launch(1'b0, 32'd5, 32'd0);
        wait_done("u_dbz", 0, 32'hFFFF_FFFF, 32'd5, 1'b1);

        @(negedge clk); launch(1'b1, 32'd5, 32'd0);
        wait_done("s_dbz", 0, 32'hFFFF_FFFF, 32'd5, 1'b1);

        // Mid-operation start is ignored; then a back-to-back start in the done cycle.
        @(negedge clk); launch(1'b0, 32'd100, 32'd7);
        wait_done("u100_7", 10, 32'd14, 32'd2, 1'b0);
        launch(1'b0, 32'd9, 32'd2);
        wait_done("b2b_9_2", 0, 32'd4, 32'd1, 1'b0);

        // Asynchronous abort at E0+15.
        @(negedge clk); launch(1'b0, 32'd100, 32'd7);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quot", quot, 32'd0);
        chk("abort_rem", rem, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        hold_q = 32'd0;
        hold_r = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); launch(1'b0, 32'd20, 32'd6);
        wait_done("u20_6", 0, 32'd3, 32'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
